// File: rtl/mem_access_unit.sv
// Sub-word load/store adapter between the EX/MEM register and a word-only data port.
// Latency: loads registered 1 cycle; word stores 1 cycle; byte/half stores 2 cycles (read-modify-write).
// Backpressure: stall asserted for the single read cycle of a sub-word store; no other stalls.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_write_data,
  output logic              mem_sig_mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              misaligned
);

  typedef enum logic {IDLE, RMW_WRITE} state_t;

  state_t            state, state_nxt;
  logic              is_store, is_load, is_mis;
  logic [ADDR_W-1:0] aligned_addr;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_data;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_ext;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              wr_c, stall_c, capture;

  // A store wins over a load when both flags are set.
  assign is_store     = ex_valid & ex_mem_write;
  assign is_load      = ex_valid & ex_mem_read & ~ex_mem_write;
  assign aligned_addr = {ex_addr[ADDR_W-1:2], 2'b00};

  // Alignment check; size 11 is reserved and always faults.
  always_comb begin
    is_mis = 1'b0;
    case (ex_size)
      2'b00:   is_mis = 1'b0;
      2'b01:   is_mis = ex_addr[0];
      2'b10:   is_mis = |ex_addr[1:0];
      default: is_mis = 1'b1;
    endcase
  end

  // Replace the addressed byte/half lane of the fetched word with the store data.
  always_comb begin
    merged = mem_read_data;
    if (ex_size == 2'b00) begin
      case (ex_addr[1:0])
        2'b00:   merged[7:0]   = ex_write_data[7:0];
        2'b01:   merged[15:8]  = ex_write_data[7:0];
        2'b10:   merged[23:16] = ex_write_data[7:0];
        default: merged[31:24] = ex_write_data[7:0];
      endcase
    end else begin
      if (ex_addr[1]) merged[31:16] = ex_write_data[15:0];
      else            merged[15:0]  = ex_write_data[15:0];
    end
  end

  // Pick the load lane (little-endian) and sign- or zero-extend it.
  always_comb begin
    case (ex_addr[1:0])
      2'b00:   byte_sel = mem_read_data[7:0];
      2'b01:   byte_sel = mem_read_data[15:8];
      2'b10:   byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    half_sel = ex_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (ex_size)
      2'b00:   load_ext = {{24{~ex_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~ex_unsigned & half_sel[15]}}, half_sel};
      default: load_ext = mem_read_data;
    endcase
  end

  // Next-state and data-port control; RMW_WRITE ignores the still-presented request.
  always_comb begin
    state_nxt      = state;
    wr_c           = 1'b0;
    stall_c        = 1'b0;
    capture        = 1'b0;
    mem_addr       = aligned_addr;
    mem_write_data = ex_write_data;
    case (state)
      IDLE: begin
        if (is_store && !is_mis) begin
          if (ex_size == 2'b10) begin
            wr_c = 1'b1;
          end else begin
            stall_c   = 1'b1;
            capture   = 1'b1;
            state_nxt = RMW_WRITE;
          end
        end
      end
      RMW_WRITE: begin
        wr_c           = 1'b1;
        mem_addr       = rmw_addr;
        mem_write_data = rmw_data;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must silence the write strobe and stall at once, even mid-RMW.
  assign mem_sig_mem_write = wr_c & rst_n;
  assign stall             = stall_c & rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Hold the merged word and its address for the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmw_addr <= '0;
      rmw_data <= '0;
    end else if (capture) begin
      rmw_addr <= aligned_addr;
      rmw_data <= merged;
    end
  end

  // Registered load result plus one-cycle load_valid / misaligned pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data  <= '0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      if (state == IDLE && (is_store || is_load)) begin
        if (is_mis) begin
          misaligned <= 1'b1;
          if (is_load) load_data <= '0;
        end else if (is_load) begin
          load_valid <= 1'b1;
          load_data  <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word memory.
// Latency: inputs driven on the falling edge, registered outputs checked 1 time unit after the rising edge.
// Backpressure: stall cycles and write strobes are counted at each rising edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_write_data;
  logic        mem_sig_mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [31:0] load_data;
  logic        load_valid, stall, misaligned;

  logic [31:0] mem [16];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0, bd_dat = '0;
  int          tests = 0, fails = 0, stall_cnt = 0, write_cnt = 0;
  int          s0, w0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr),
    .ex_write_data(ex_write_data),
    .mem_sig_mem_write(mem_sig_mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .load_data(load_data), .load_valid(load_valid), .stall(stall),
    .misaligned(misaligned)
  );

  function automatic logic [3:0] widx(input logic [31:0] a);
    return {a[13:12], a[3:2]};
  endfunction

  assign mem_read_data = mem[widx(mem_addr)];

  // Word memory with a backdoor preload port; also counts writes and stall cycles.
  always @(posedge clk) begin
    if (bd_we) mem[widx(bd_addr)] <= bd_dat;
    else if (mem_sig_mem_write) begin
      mem[widx(mem_addr)] <= mem_write_data;
      write_cnt <= write_cnt + 1;
    end
    if (stall) stall_cnt <= stall_cnt + 1;
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_size = sz; ex_unsigned = uns; ex_addr = a; ex_write_data = wd;
  endtask

  task automatic no_req();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_size = 2'b10; ex_unsigned = 1'b0; ex_addr = '0; ex_write_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    no_req();
    #1;
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL rst_load_valid got %b want 0", load_valid); end
    tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL rst_load_data got %h want 00000000", load_data); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL rst_misaligned got %b want 0", misaligned); end
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678);
    #1;
    tests++; if (mem_sig_mem_write !== 1'b0) begin fails++; $display("FAIL rst_write_gated got %b want 0", mem_sig_mem_write); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", stall); end
    no_req();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sb_rmw();
    preload(32'h1000, 32'hdeadbeef);
    @(negedge clk);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001, 32'h000000aa);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_stall got %b want 1", stall); end
    tests++; if (mem_sig_mem_write !== 1'b0) begin fails++; $display("FAIL sb_read_phase_we got %b want 0", mem_sig_mem_write); end
    tests++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL sb_read_addr got %h want 00001000", mem_addr); end
    @(negedge clk); #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_wr_stall got %b want 0", stall); end
    tests++; if (mem_sig_mem_write !== 1'b1) begin fails++; $display("FAIL sb_wr_we got %b want 1", mem_sig_mem_write); end
    tests++; if (mem_write_data !== 32'hdeadaaef) begin fails++; $display("FAIL sb_wr_data got %h want deadaaef", mem_write_data); end
    tests++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL sb_wr_addr got %h want 00001000", mem_addr); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_valid !== 1'b1) begin fails++; $display("FAIL sb_lw_valid got %b want 1", load_valid); end
    tests++; if (load_data !== 32'hdeadaaef) begin fails++; $display("FAIL sb_lw_data got %h want deadaaef", load_data); end
    @(negedge clk);
    no_req();
    @(posedge clk); #1;
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL lw_pulse_width got %b want 0", load_valid); end
  endtask

  task automatic test_sh_and_half_loads();
    preload(32'h1000, 32'hdeadbeef);
    @(negedge clk);
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h1002, 32'h00001234);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sh_stall got %b want 1", stall); end
    @(negedge clk); #1;
    tests++; if (mem_write_data !== 32'h1234beef) begin fails++; $display("FAIL sh_wr_data got %h want 1234beef", mem_write_data); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h1002, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'h00001234) begin fails++; $display("FAIL lh_upper got %h want 00001234", load_data); end
    preload(32'h1000, 32'hdeadbeef);
    @(negedge clk);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'hffffbeef) begin fails++; $display("FAIL lh_signed got %h want ffffbeef", load_data); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b01, 1'b1, 32'h1000, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'h0000beef) begin fails++; $display("FAIL lhu got %h want 0000beef", load_data); end
    tests++; if (load_valid !== 1'b1) begin fails++; $display("FAIL lhu_valid got %b want 1", load_valid); end
    @(negedge clk);
    no_req();
  endtask

  task automatic test_byte_loads();
    @(negedge clk);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'hffffffde) begin fails++; $display("FAIL lb_1003 got %h want ffffffde", load_data); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'h000000de) begin fails++; $display("FAIL lbu_1003 got %h want 000000de", load_data); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'hffffffef) begin fails++; $display("FAIL lb_1000 got %h want ffffffef", load_data); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h1002, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_data !== 32'h000000ad) begin fails++; $display("FAIL lbu_1002 got %h want 000000ad", load_data); end
    @(negedge clk);
    no_req();
  endtask

  task automatic test_misaligned();
    w0 = write_cnt;
    @(negedge clk);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis_lw_stall got %b want 0", stall); end
    @(posedge clk); #1;
    tests++; if (misaligned !== 1'b1) begin fails++; $display("FAIL mis_lw_pulse got %b want 1", misaligned); end
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL mis_lw_valid got %b want 0", load_valid); end
    tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL mis_lw_data got %h want 00000000", load_data); end
    @(negedge clk);
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001, 32'h0000ffff);
    #1;
    tests++; if (mem_sig_mem_write !== 1'b0) begin fails++; $display("FAIL mis_sh_we got %b want 0", mem_sig_mem_write); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis_sh_stall got %b want 0", stall); end
    @(posedge clk); #1;
    tests++; if (misaligned !== 1'b1) begin fails++; $display("FAIL mis_sh_pulse got %b want 1", misaligned); end
    @(negedge clk);
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    tests++; if (misaligned !== 1'b1) begin fails++; $display("FAIL mis_size11 got %b want 1", misaligned); end
    @(negedge clk);
    no_req();
    @(posedge clk); #1;
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL mis_pulse_width got %b want 0", misaligned); end
    tests++; if (write_cnt !== w0) begin fails++; $display("FAIL mis_no_write got %0d writes want %0d", write_cnt, w0); end
    tests++; if (mem[widx(32'h1000)] !== 32'hdeadbeef) begin fails++; $display("FAIL mis_mem_kept got %h want deadbeef", mem[widx(32'h1000)]); end
  endtask

  task automatic test_back_to_back();
    preload(32'h2000, 32'h00000000);
    s0 = stall_cnt; w0 = write_cnt;
    @(negedge clk);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h2000, 32'h00000011);
    @(negedge clk); #1;
    tests++; if (mem_write_data !== 32'h00000011) begin fails++; $display("FAIL b2b_first_data got %h want 00000011", mem_write_data); end
    @(negedge clk);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h2001, 32'h00000022);
    @(negedge clk); #1;
    tests++; if (mem_write_data !== 32'h00002211) begin fails++; $display("FAIL b2b_second_data got %h want 00002211", mem_write_data); end
    @(negedge clk);
    no_req();
    @(posedge clk); #1;
    tests++; if (stall_cnt - s0 !== 2) begin fails++; $display("FAIL b2b_stall_cycles got %0d want 2", stall_cnt - s0); end
    tests++; if (write_cnt - w0 !== 2) begin fails++; $display("FAIL b2b_write_count got %0d want 2", write_cnt - w0); end
    tests++; if (mem[widx(32'h2000)] !== 32'h00002211) begin fails++; $display("FAIL b2b_final_word got %h want 00002211", mem[widx(32'h2000)]); end
  endtask

  task automatic test_reset_in_rmw();
    preload(32'h1000, 32'hdeadbeef);
    w0 = write_cnt;
    @(negedge clk);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    @(negedge clk);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h1000, 32'h00000055);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if (mem_sig_mem_write !== 1'b0) begin fails++; $display("FAIL rmw_rst_we got %b want 0", mem_sig_mem_write); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rmw_rst_stall got %b want 0", stall); end
    @(negedge clk);
    no_req();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL rmw_rst_load_data got %h want 00000000", load_data); end
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL rmw_rst_load_valid got %b want 0", load_valid); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL rmw_rst_misaligned got %b want 0", misaligned); end
    tests++; if (mem_sig_mem_write !== 1'b0) begin fails++; $display("FAIL rmw_rst_idle_we got %b want 0", mem_sig_mem_write); end
    tests++; if (write_cnt !== w0) begin fails++; $display("FAIL rmw_rst_no_write got %0d writes want %0d", write_cnt, w0); end
    tests++; if (mem[widx(32'h1000)] !== 32'hdeadbeef) begin fails++; $display("FAIL rmw_rst_mem got %h want deadbeef", mem[widx(32'h1000)]); end
    @(negedge clk);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    tests++; if (load_valid !== 1'b1) begin fails++; $display("FAIL rmw_rst_idle_lw_valid got %b want 1", load_valid); end
    tests++; if (load_data !== 32'hdeadbeef) begin fails++; $display("FAIL rmw_rst_idle_lw_data got %h want deadbeef", load_data); end
    @(negedge clk);
    no_req();
  endtask

  task automatic test_word_store_and_both_flags();
    w0 = write_cnt;
    @(negedge clk);
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h1004, 32'hcafef00d);
    #1;
    tests++; if (mem_sig_mem_write !== 1'b1) begin fails++; $display("FAIL sw_we got %b want 1", mem_sig_mem_write); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sw_stall got %b want 0", stall); end
    @(posedge clk); #1;
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL sw_both_no_load got %b want 0", load_valid); end
    @(negedge clk);
    no_req();
    #1;
    tests++; if (mem_sig_mem_write !== 1'b0) begin fails++; $display("FAIL idle_we got %b want 0", mem_sig_mem_write); end
    tests++; if (mem[widx(32'h1004)] !== 32'hcafef00d) begin fails++; $display("FAIL sw_mem got %h want cafef00d", mem[widx(32'h1004)]); end
    tests++; if (write_cnt - w0 !== 1) begin fails++; $display("FAIL sw_write_count got %0d want 1", write_cnt - w0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sb_rmw();
    test_sh_and_half_loads();
    test_byte_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_in_rmw();
    test_word_store_and_both_flags();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
